ram_arbiter_2: RTL and testbench

//  Shares one single-port synchronous RAM (1-cycle read latency, write-enable) between two requesters.

---
 rtl/ram_arbiter_2.sv | 139 +++++++++++++
 tb/tb_ram_arbiter_2.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_2.sv
// Two-requester round-robin front end for a single-port synchronous RAM.
// One RAM access per cycle. Read data returns to whichever requester issued the read.
// An optional post-reset sweep writes INIT_VALUE to every entry before any grant is issued.
module ram_arbiter_2 #(
    parameter int                SIZE           = 8,
    parameter int                DEPTH          = 16,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter logic [SIZE-1:0]   INIT_VALUE     = '0,
    localparam int               AW             = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            r0_req,
    input  logic            r0_we,
    input  logic [AW-1:0]   r0_addr,
    input  logic [SIZE-1:0] r0_wdata,
    output logic            r0_gnt,
    output logic            r0_rvalid,
    output logic [SIZE-1:0] r0_rdata,

    input  logic            r1_req,
    input  logic            r1_we,
    input  logic [AW-1:0]   r1_addr,
    input  logic [SIZE-1:0] r1_wdata,
    output logic            r1_gnt,
    output logic            r1_rvalid,
    output logic [SIZE-1:0] r1_rdata,

    output logic            busy,

    output logic [AW-1:0]   ram_address,
    output logic [SIZE-1:0] ram_write_data,
    output logic            ram_write_en,
    input  logic [SIZE-1:0] ram_read_data
);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    localparam state_t        RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    localparam logic [AW-1:0] LAST_ADDR   = AW'(DEPTH - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q;
    logic            prio_q, prio_d;
    logic            rv0_q, rv0_d;
    logic            rv1_q, rv1_d;

    // State register: sweep first (if enabled), then normal arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave the sweep once the last entry has been written.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_CLEAR && cnt_q == LAST_ADDR) begin
            state_d = ST_RUN;
        end
    end

    // Outputs: sweep writes, or round-robin grant with the winner driving the RAM port.
    always_comb begin
        busy           = 1'b0;
        r0_gnt         = 1'b0;
        r1_gnt         = 1'b0;
        ram_address    = addr_q;
        ram_write_data = '0;
        ram_write_en   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                busy           = 1'b1;
                ram_write_en   = 1'b1;
                ram_address    = cnt_q;
                ram_write_data = INIT_VALUE;
            end
            ST_RUN: begin
                // prio_q names the requester that wins when both ask.
                r0_gnt = r0_req & (~r1_req | ~prio_q);
                r1_gnt = r1_req & (~r0_req |  prio_q);
                if (r0_gnt) begin
                    ram_address    = r0_addr;
                    ram_write_data = r0_wdata;
                    ram_write_en   = r0_we;
                end else if (r1_gnt) begin
                    ram_address    = r1_addr;
                    ram_write_data = r1_wdata;
                    ram_write_en   = r1_we;
                end
            end
            default: ;
        endcase
    end

    // Next values for sweep counter, priority pointer and read-return flags.
    always_comb begin
        cnt_d  = cnt_q;
        prio_d = prio_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
        end
        // The requester that just lost (or did not ask) gets priority next time.
        if (r0_gnt) begin
            prio_d = 1'b1;
        end else if (r1_gnt) begin
            prio_d = 1'b0;
        end
        rv0_d = r0_gnt & ~r0_we;
        rv1_d = r1_gnt & ~r1_we;
    end

    // Control registers; the held address keeps the RAM port stable on idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            addr_q <= '0;
            prio_q <= 1'b0;
            rv0_q  <= 1'b0;
            rv1_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= ram_address;
            prio_q <= prio_d;
            rv0_q  <= rv0_d;
            rv1_q  <= rv1_d;
        end
    end

    assign r0_rvalid = rv0_q;
    assign r1_rvalid = rv1_q;
    assign r0_rdata  = ram_read_data;
    assign r1_rdata  = ram_read_data;

endmodule

// File: tb/tb_ram_arbiter_2.sv
// Bench for ram_arbiter_2: directed vector table, hand sequences for reset and
// back-to-back reads, and random traffic checked against a behavioural model.
module tb_ram_arbiter_2;
    localparam int          SIZE  = 8;
    localparam int          DEPTH = 16;
    localparam int          AW    = 4;
    localparam logic [7:0]  INIT  = 8'hA5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: sweep enabled ----------------
    logic            rst;
    logic            r0_req, r0_we, r1_req, r1_we;
    logic [AW-1:0]   r0_addr, r1_addr;
    logic [SIZE-1:0] r0_wdata, r1_wdata;
    logic            r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, busy, ram_we;
    logic [SIZE-1:0] r0_rdata, r1_rdata, ram_wd, ram_rd;
    logic [AW-1:0]   ram_addr;
    logic [SIZE-1:0] ram_mem [DEPTH];

    ram_arbiter_2 #(.SIZE(SIZE), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1), .INIT_VALUE(INIT)) dut_a (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .busy(busy), .ram_address(ram_addr), .ram_write_data(ram_wd),
        .ram_write_en(ram_we), .ram_read_data(ram_rd)
    );

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wd;
        ram_rd <= ram_mem[ram_addr];
    end

    // ---------------- instance B: no sweep, read-only RAM image ----------------
    logic            b_rst, b_r0_req, b_r0_we, b_r1_req, b_r1_we;
    logic [AW-1:0]   b_r0_addr, b_r1_addr, b_ram_addr;
    logic [SIZE-1:0] b_r0_wdata, b_r1_wdata, b_r0_rdata, b_r1_rdata, b_ram_wd, b_ram_rd;
    logic            b_r0_gnt, b_r0_rvalid, b_r1_gnt, b_r1_rvalid, b_busy, b_ram_we;

    ram_arbiter_2 #(.SIZE(SIZE), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b0), .INIT_VALUE(INIT)) dut_b (
        .clk(clk), .rst(b_rst),
        .r0_req(b_r0_req), .r0_we(b_r0_we), .r0_addr(b_r0_addr), .r0_wdata(b_r0_wdata),
        .r0_gnt(b_r0_gnt), .r0_rvalid(b_r0_rvalid), .r0_rdata(b_r0_rdata),
        .r1_req(b_r1_req), .r1_we(b_r1_we), .r1_addr(b_r1_addr), .r1_wdata(b_r1_wdata),
        .r1_gnt(b_r1_gnt), .r1_rvalid(b_r1_rvalid), .r1_rdata(b_r1_rdata),
        .busy(b_busy), .ram_address(b_ram_addr), .ram_write_data(b_ram_wd),
        .ram_write_en(b_ram_we), .ram_read_data(b_ram_rd)
    );

    function automatic logic [7:0] b_val(input logic [3:0] a);
        return 8'(a * 7 + 3);
    endfunction

    always @(posedge clk) b_ram_rd <= b_val(b_ram_addr);

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of instance A ----------------
    int          sweep_left;     // remaining sweep writes
    logic        prio_m;         // requester favoured on a tie
    logic [3:0]  last_addr_m;    // address last presented to the RAM
    logic        rv0_m, rv1_m;
    logic [7:0]  rd0_m, rd1_m;
    logic [7:0]  mem_m [DEPTH];

    task automatic reset_model();
        sweep_left  = DEPTH;
        prio_m      = 1'b0;
        last_addr_m = 4'd0;
        rv0_m       = 1'b0;
        rv1_m       = 1'b0;
    endtask

    // One clock of instance A: check outputs mid-cycle, then advance the model.
    task automatic cycle();
        int         winner;
        logic       e_g0, e_g1, e_we;
        logic [3:0] e_addr;
        logic [7:0] e_wd, nrd;
        #3;
        winner = -1;
        e_wd   = 8'h00;
        if (sweep_left > 0) begin
            e_g0 = 1'b0; e_g1 = 1'b0; e_we = 1'b1;
            e_addr = 4'(DEPTH - sweep_left);
            e_wd   = INIT;
        end else begin
            if (r0_req && r1_req) winner = int'(prio_m);
            else if (r0_req)      winner = 0;
            else if (r1_req)      winner = 1;
            e_g0 = (winner == 0);
            e_g1 = (winner == 1);
            if (winner == 0) begin
                e_we = r0_we; e_addr = r0_addr; e_wd = r0_wdata;
            end else if (winner == 1) begin
                e_we = r1_we; e_addr = r1_addr; e_wd = r1_wdata;
            end else begin
                e_we = 1'b0; e_addr = last_addr_m;
            end
        end
        chk1("busy", busy, sweep_left > 0);
        chk1("r0_gnt", r0_gnt, e_g0);
        chk1("r1_gnt", r1_gnt, e_g1);
        chk1("ram_write_en", ram_we, e_we);
        chk4("ram_address", ram_addr, e_addr);
        if (e_we) chk8("ram_write_data", ram_wd, e_wd);
        chk1("r0_rvalid", r0_rvalid, rv0_m);
        chk1("r1_rvalid", r1_rvalid, rv1_m);
        if (rv0_m) chk8("r0_rdata", r0_rdata, rd0_m);
        if (rv1_m) chk8("r1_rdata", r1_rdata, rd1_m);
        nrd = mem_m[e_addr];
        @(posedge clk);
        if (e_we) mem_m[e_addr] = e_wd;
        if (rst) begin
            reset_model();
        end else begin
            if (sweep_left > 0) sweep_left--;
            rv0_m = e_g0 && !r0_we;
            rv1_m = e_g1 && !r1_we;
            rd0_m = nrd;
            rd1_m = nrd;
            if (e_g0) prio_m = 1'b1;
            else if (e_g1) prio_m = 1'b0;
            last_addr_m = e_addr;
        end
        #1;
    endtask

    task automatic idle_a();
        r0_req = 1'b0; r0_we = 1'b0; r1_req = 1'b0; r1_we = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       q0, w0;
        logic [3:0] a0;
        logic [7:0] d0;
        logic       q1, w1;
        logic [3:0] a1;
        logic [7:0] d1;
        logic       g0, g1, v0, v1;
        logic [7:0] rd;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input int q0, w0, a0, d0, q1, w1, a1, d1,
                                input int g0, g1, v0, v1, rd);
        vec_t v;
        v.q0 = q0[0]; v.w0 = w0[0]; v.a0 = 4'(a0); v.d0 = 8'(d0);
        v.q1 = q1[0]; v.w1 = w1[0]; v.a1 = 4'(a1); v.d1 = 8'(d1);
        v.g0 = g0[0]; v.g1 = g1[0]; v.v0 = v0[0]; v.v1 = v1[0]; v.rd = 8'(rd);
        return v;
    endfunction

    initial begin
        //            q0 w0 a0 d0     q1 w1 a1 d1     g0 g1 v0 v1 rd
        tbl[0]  = mk(1, 0, 7, 0,     0, 0, 0, 0,     1, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 3, 'h11,  0, 0, 0, 0,     1, 0, 1, 0, 'hA5);
        tbl[2]  = mk(1, 0, 3, 0,     0, 0, 0, 0,     1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 1, 0, 'h11);
        tbl[4]  = mk(0, 0, 0, 0,     1, 1, 9, 'h5A,  0, 1, 0, 0, 0);
        tbl[5]  = mk(1, 0, 1, 0,     1, 0, 2, 0,     1, 0, 0, 0, 0);
        tbl[6]  = mk(1, 0, 1, 0,     1, 0, 2, 0,     0, 1, 1, 0, 'hA5);
        tbl[7]  = mk(1, 0, 1, 0,     1, 0, 2, 0,     1, 0, 0, 1, 'hA5);
        tbl[8]  = mk(1, 0, 1, 0,     1, 0, 2, 0,     0, 1, 1, 0, 'hA5);
        tbl[9]  = mk(1, 0, 1, 0,     1, 0, 2, 0,     1, 0, 0, 1, 'hA5);
        tbl[10] = mk(1, 0, 1, 0,     1, 0, 2, 0,     0, 1, 1, 0, 'hA5);
        tbl[11] = mk(1, 0, 5, 0,     1, 1, 5, 'h3C,  1, 0, 0, 1, 'hA5);
        tbl[12] = mk(0, 0, 0, 0,     1, 1, 5, 'h3C,  0, 1, 1, 0, 'hA5);
        tbl[13] = mk(0, 0, 0, 0,     1, 0, 5, 0,     0, 1, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 0, 1, 'h3C);
        tbl[15] = mk(1, 0, 9, 0,     0, 0, 0, 0,     1, 0, 0, 0, 0);
        tbl[16] = mk(0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 1, 0, 'h5A);

        rst = 1'b1; idle_a();
        r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;
        b_rst = 1'b1; b_r0_req = 1'b0; b_r0_we = 1'b0; b_r0_addr = '0; b_r0_wdata = '0;
        b_r1_req = 1'b0; b_r1_we = 1'b0; b_r1_addr = '0; b_r1_wdata = '0;

        repeat (2) @(posedge clk);
        #1;
        reset_model();
        rst = 1'b0;

        // Reset state and full sweep: busy, write enable, addresses 0..15.
        chk1("reset_busy", busy, 1'b1);
        chk1("reset_we", ram_we, 1'b1);
        chk4("reset_addr", ram_addr, 4'd0);
        chk1("reset_rvalid0", r0_rvalid, 1'b0);
        chk1("reset_rvalid1", r1_rvalid, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle();
        chk1("sweep_done_busy", busy, 1'b0);

        // Directed vectors.
        for (int i = 0; i < 17; i++) begin
            r0_req = tbl[i].q0; r0_we = tbl[i].w0; r0_addr = tbl[i].a0; r0_wdata = tbl[i].d0;
            r1_req = tbl[i].q1; r1_we = tbl[i].w1; r1_addr = tbl[i].a1; r1_wdata = tbl[i].d1;
            #3;
            chk1($sformatf("vec%0d_gnt0", i), r0_gnt, tbl[i].g0);
            chk1($sformatf("vec%0d_gnt1", i), r1_gnt, tbl[i].g1);
            chk1($sformatf("vec%0d_rvalid0", i), r0_rvalid, tbl[i].v0);
            chk1($sformatf("vec%0d_rvalid1", i), r1_rvalid, tbl[i].v1);
            if (tbl[i].v0) chk8($sformatf("vec%0d_rdata0", i), r0_rdata, tbl[i].rd);
            if (tbl[i].v1) chk8($sformatf("vec%0d_rdata1", i), r1_rdata, tbl[i].rd);
            cycle();
        end

        // Reset the cycle after an r1 read grant: read dropped, sweep restarts.
        idle_a();
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 4'd4;
        cycle();
        idle_a();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk1("rst_mid_rvalid1", r1_rvalid, 1'b0);
        chk1("rst_mid_busy", busy, 1'b1);
        chk4("rst_mid_addr", ram_addr, 4'd0);
        for (int i = 0; i < DEPTH; i++) cycle();

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            r0_req   = 1'($urandom_range(0, 1));
            r0_we    = 1'($urandom_range(0, 1));
            r0_addr  = 4'($urandom_range(0, DEPTH - 1));
            r0_wdata = 8'($urandom);
            r1_req   = 1'($urandom_range(0, 1));
            r1_we    = 1'($urandom_range(0, 1));
            r1_addr  = 4'($urandom_range(0, DEPTH - 1));
            r1_wdata = 8'($urandom);
            rst      = ($urandom_range(0, 79) == 0);
            cycle();
        end
        rst = 1'b0;
        idle_a();

        // Instance B: no sweep, four back-to-back r1 reads.
        @(posedge clk);
        #1;
        b_rst = 1'b0;
        #3;
        chk1("b_reset_busy", b_busy, 1'b0);
        chk1("b_reset_we", b_ram_we, 1'b0);
        chk4("b_reset_addr", b_ram_addr, 4'd0);
        chk1("b_reset_rvalid1", b_r1_rvalid, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            logic [3:0] a;
            logic [3:0] pa;
            a  = 4'(i * 4 + 2);
            pa = 4'((i - 1) * 4 + 2);
            b_r1_req = (i < 4);
            b_r1_we = 1'b0;
            b_r1_addr = a;
            #3;
            chk1($sformatf("b_gnt1_%0d", i), b_r1_gnt, i < 4);
            chk1($sformatf("b_gnt0_%0d", i), b_r0_gnt, 1'b0);
            if (i < 4) chk4($sformatf("b_addr_%0d", i), b_ram_addr, a);
            chk1($sformatf("b_rvalid1_%0d", i), b_r1_rvalid, i > 0);
            chk1($sformatf("b_rvalid0_%0d", i), b_r0_rvalid, 1'b0);
            if (i > 0) chk8($sformatf("b_rdata1_%0d", i), b_r1_rdata, b_val(pa));
            @(posedge clk);
            #1;
        end
        b_r1_req = 1'b0;
        #3;
        chk1("b_rvalid1_end", b_r1_rvalid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
